case_code_decoder: RTL and testbench

Receive-side decoder for the 4-bit case-encoded nibbles produced by the select encoders (unique, wildcard and default tables). It accepts one code word per handshake, recovers the 2-bit select value according to the table named by `mode`, flags codes that are ambiguous or illegal, and buffers results in a 2-entry output FIFO. It sits between the nibble link and the select consumer and keeps a saturating count of illegal words.

---
 rtl/case_code_decoder.sv | 140 ++++++++++++++
 tb/tb_case_code_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/case_code_decoder.sv
// Case-code nibble decoder: unique/wildcard/default tables into a 2-entry result FIFO.
// Optional feature macro: CASE_DEC_ERR_COUNT_EN builds the 8-bit saturating illegal-word counter.
module case_code_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_code,
    input  logic [1:0] in_mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_select,
    output logic       out_amb,
    output logic       out_err,
    output logic [7:0] err_count
);

    // Result word layout: {select[1:0], amb, err}
    function automatic logic [3:0] decode_f(input logic [1:0] mode, input logic [3:0] code);
        logic [3:0] r;
        r = 4'b0001;
        case (mode)
            2'd0: begin
                case (code)
                    4'ha:    r = 4'b0000;
                    4'h6:    r = 4'b0100;
                    4'h3:    r = 4'b1000;
                    4'h0:    r = 4'b1100;
                    default: r = 4'b0001;
                endcase
            end
            2'd1: begin
                case (code)
                    4'h3:    r = 4'b0000;
                    4'h0:    r = 4'b0100;
                    4'hd:    r = 4'b1010;
                    default: r = 4'b0001;
                endcase
            end
            2'd2: begin
                case (code)
                    4'h7:    r = 4'b0000;
                    4'h9:    r = 4'b0100;
                    4'h8:    r = 4'b1010;
                    default: r = 4'b0001;
                endcase
            end
            default: r = 4'b0001;
        endcase
        return r;
    endfunction

    logic [1:0][3:0] entry_q, entry_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push_s, pop_s;
    logic [3:0]      dec_s;
    logic [3:0]      head_s;

    // Handshake, decode and FIFO next-state
    always_comb begin
        in_ready  = (count_q != 2'd2) || out_ready;
        out_valid = (count_q != 2'd0);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        dec_s     = decode_f(in_mode, in_code);
        entry_d   = entry_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_s) begin
            entry_d[wr_ptr_q] = dec_s;
            wr_ptr_d          = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Simultaneous push and pop leaves the occupancy unchanged
        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // FIFO state registers; reset discards buffered entries and any same-cycle accept
    always_ff @(posedge clock) begin
        if (reset) begin
            entry_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_s     = entry_q[rd_ptr_q];
    assign out_select = head_s[3:2];
    assign out_amb    = head_s[1];
    assign out_err    = head_s[0];

`ifdef CASE_DEC_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count of accepted illegal words
    always_comb begin
        err_count_d = err_count_q;
        if (push_s && dec_s[0] && (err_count_q != 8'd255)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_case_code_decoder.sv
// Self-checking bench for case_code_decoder: directed steps plus random traffic vs a table-driven model.
module tb_case_code_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_select;
    logic       out_amb;
    logic       out_err;
    logic [7:0] err_count;

    case_code_decoder dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select),
        .out_amb    (out_amb),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int sel;
        bit amb;
        bit err;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t q[$];
    int   cnt;
    // Legal codes per table, indexed by the select value they carry; -1 = unused slot
    int   tbl[3][4] = '{'{10, 6, 3, 0}, '{3, 0, 13, -1}, '{7, 9, 8, -1}};

    function automatic res_t ref_dec(int mode, int code);
        res_t r;
        r.sel = 0; r.amb = 1'b0; r.err = 1'b1;
        if (mode < 3) begin
            for (int i = 0; i < 4; i++) begin
                if (r.err && tbl[mode][i] == code) begin
                    r.sel = i;
                    r.err = 1'b0;
                    r.amb = (mode != 0) && (i == 2);
                end
            end
        end
        return r;
    endfunction

    function automatic int exp_ec();
`ifdef CASE_DEC_ERR_COUNT_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_select", int'(out_select), q[0].sel);
            chk("out_amb", int'(out_amb), int'(q[0].amb));
            chk("out_err", int'(out_err), int'(q[0].err));
        end
        chk("err_count", int'(err_count), exp_ec());
    endtask

    // One clock cycle of traffic, with the model advanced at the same edge
    task automatic step(input bit v, input int code, input int mode, input bit ordy);
        bit exp_rdy, acc, pop;
        @(negedge clock);
        in_valid  = v;
        in_code   = code[3:0];
        in_mode   = mode[1:0];
        out_ready = ordy;
        #1;
        exp_rdy = (q.size() != 2) || ordy;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        acc = v && exp_rdy;
        pop = (q.size() != 0) && ordy;
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(ref_dec(mode, code));
            if (ref_dec(mode, code).err && cnt < 255) cnt++;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 4'h7;
        in_mode   = 2'd3;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        cnt = 0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_select", int'(out_select), 0);
        chk("rst_out_amb", int'(out_amb), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_code = 4'h0; in_mode = 2'd0; out_ready = 1'b0;
        cnt = 0;
        do_reset();

        // Mode 0 stream a,6,3,0 -> selects 0,1,2,3 back to back
        step(1'b1, 10, 0, 1'b1);
        chk("m0_first_sel", int'(out_select), 0);
        step(1'b1, 6, 0, 1'b1);
        step(1'b1, 3, 0, 1'b1);
        step(1'b1, 0, 0, 1'b1);
        chk("m0_last_sel", int'(out_select), 3);
        step(1'b0, 0, 0, 1'b1);

        // Ambiguous and illegal codes
        step(1'b1, 13, 1, 1'b1);
        chk("m1_amb", int'(out_amb), 1);
        step(1'b1, 8, 2, 1'b1);
        step(1'b1, 0, 2, 1'b1);
        chk("m2_zero_err", int'(out_err), 1);
        step(1'b1, 7, 3, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        chk("two_errors", int'(err_count), exp_ec());

        // Backpressure: fill, stall third word, then release with simultaneous push/pop
        step(1'b1, 9, 2, 1'b0);
        step(1'b1, 3, 1, 1'b0);
        step(1'b1, 6, 0, 1'b0);
        chk("full_in_ready", int'(in_ready), 0);
        step(1'b1, 6, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);

        // Saturation of the illegal-word counter
        for (int i = 0; i < 300; i++) step(1'b1, i % 16, 3, 1'b1);
        step(1'b0, 0, 0, 1'b1);

        // Reset with two entries buffered
        step(1'b1, 10, 0, 1'b0);
        step(1'b1, 6, 0, 1'b0);
        do_reset();
        step(1'b1, 3, 0, 1'b1);
        step(1'b1, 9, 2, 1'b1);
        step(1'b0, 0, 0, 1'b1);

        // Continuous push/pop across pointer wrap
        for (int i = 0; i < 8; i++) begin
            int m;
            m = int'($urandom_range(0, 2));
            step(1'b1, tbl[m][i % 3], m, 1'b1);
        end
        step(1'b0, 0, 0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
